cam_stream_gen: RTL and testbench

Camera-side source for the pixel capture path. It generates an OV7670-style byte stream (vsync, href and an 8-bit data bus) synchronous to the pixel clock, carrying RGB565 pixels from a built-in test pattern. It drives the capture FIFO's href/vsync/din inputs in simulation and on-board bring-up, replacing the physical sensor.

---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_colorbar_lut.sv | 11 +
 rtl/cam_stream_gen.sv | 146 ++++++++++++++
 tb/tb_cam_stream_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera test-pattern stream generator.
package cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } cam_state_e;

    typedef enum logic {
        PatRamp = 1'b0,
        PatBars = 1'b1
    } cam_pattern_e;

    // RGB565 bar colours; index 0 is the leftmost bar.
    localparam logic [7:0][15:0] ColorBars = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/cam_colorbar_lut.sv
// Combinational colour-bar lookup: bar index to RGB565 colour.
module cam_colorbar_lut
    import cam_pkg::*;
(
    input  logic [2:0]  bar_idx,
    output logic [15:0] rgb
);

    assign rgb = ColorBars[bar_idx];

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style vsync/href/byte stream source carrying an RGB565 test pattern.
// Outputs are registered from a decode of the current state, one pclk behind it.
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 160,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned V_ACTIVE = 120,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       en,
    input  logic       pattern,
    output logic       vsync,
    output logic       href,
    output logic [7:0] dout,
    output logic       frame_done
);

    localparam int unsigned LP        = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned CYC_W     = $clog2(LP);
    localparam int unsigned V_MAX_A   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int unsigned V_MAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned V_MAX     = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int unsigned LINE_W    = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam int unsigned BAR_BYTES = H_ACTIVE / 4;
    localparam int unsigned BAR_W     = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;

    cam_state_e       state_q, state_d;
    cam_pattern_e     pat_q, pat_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [7:0]       ramp_q, ramp_d;
    logic [BAR_W-1:0] bar_byte_q, bar_byte_d;
    logic [2:0]       bar_idx_q, bar_idx_d;

    logic             vsync_d, href_d, frame_done_d;
    logic [7:0]       dout_d;
    logic [LINE_W-1:0] line_term;
    logic             cyc_last, phase_last, active_byte;
    logic [15:0]      bar_rgb;

    cam_colorbar_lut u_lut (
        .bar_idx (bar_idx_q),
        .rgb     (bar_rgb)
    );

    always_comb begin
        unique case (state_q)
            StVsync:  line_term = LINE_W'(V_SYNC - 1);
            StVback:  line_term = LINE_W'(V_BACK - 1);
            StActive: line_term = LINE_W'(V_ACTIVE - 1);
            StVfront: line_term = LINE_W'(V_FRONT - 1);
            default:  line_term = '0;
        endcase
        cyc_last    = (cyc_q == CYC_W'(LP - 1));
        phase_last  = cyc_last && (line_q == line_term);
        active_byte = (state_q == StActive) && (cyc_q < CYC_W'(2 * H_ACTIVE));
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        cyc_d      = cyc_q;
        line_d     = line_q;
        ramp_d     = ramp_q;
        bar_byte_d = '0;
        bar_idx_d  = '0;

        if (state_q != StIdle) begin
            cyc_d = cyc_last ? '0 : cyc_q + 1'b1;
            if (cyc_last) begin
                line_d = phase_last ? '0 : line_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle:   if (en) state_d = StVsync;
            StVsync:  if (phase_last) state_d = StVback;
            StVback:  if (phase_last) state_d = StActive;
            StActive: if (phase_last) state_d = StVfront;
            StVfront: if (phase_last) state_d = en ? StVsync : StIdle;
            default:  state_d = StIdle;
        endcase

        // Bar tracking restarts every line; the last active byte wraps it back to bar 0.
        if (active_byte) begin
            ramp_d = ramp_q + 1'b1;
            if (bar_byte_q == BAR_W'(BAR_BYTES - 1)) begin
                bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                bar_byte_d = bar_byte_q + 1'b1;
                bar_idx_d  = bar_idx_q;
            end
        end

        if ((state_d == StVsync) && (state_q != StVsync)) begin
            ramp_d = '0;
            pat_d  = cam_pattern_e'(pattern);
        end

        vsync_d      = (state_q == StVsync);
        href_d       = active_byte;
        frame_done_d = (state_q == StVfront) && phase_last;
        dout_d       = '0;
        if (active_byte) begin
            if (pat_q == PatBars) begin
                dout_d = cyc_q[0] ? bar_rgb[7:0] : bar_rgb[15:8];
            end else begin
                dout_d = ramp_q;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pat_q      <= PatRamp;
            cyc_q      <= '0;
            line_q     <= '0;
            ramp_q     <= '0;
            bar_byte_q <= '0;
            bar_idx_q  <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            dout       <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            cyc_q      <= cyc_d;
            line_q     <= line_d;
            ramp_q     <= ramp_d;
            bar_byte_q <= bar_byte_d;
            bar_idx_q  <= bar_idx_d;
            vsync      <= vsync_d;
            href       <= href_d;
            dout       <= dout_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen with a small frame (LP=20, 100-cycle frames).
module tb_cam_stream_gen;

    logic       pclk = 1'b0;
    logic       reset;
    logic       en;
    logic       pattern;
    logic       vsync, href, frame_done;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;
    int gn    = 0;

    logic       cvs [700];
    logic       chr [700];
    logic       cfd [700];
    logic [7:0] cd  [700];

    logic [7:0] bar_bytes [16] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
        8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00
    };

    cam_stream_gen #(
        .H_ACTIVE (8),
        .H_BLANK  (4),
        .V_SYNC   (1),
        .V_BACK   (1),
        .V_ACTIVE (2),
        .V_FRONT  (1)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .en         (en),
        .pattern    (pattern),
        .vsync      (vsync),
        .href       (href),
        .dout       (dout),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        gn++;
        cvs[gn] = vsync;
        chr[gn] = href;
        cfd[gn] = frame_done;
        cd[gn]  = dout;
    endtask

    // Expected {vsync, href, frame_done, dout} at position p (1..100) of a frame.
    function automatic logic [10:0] exp_at(input int p, input logic pat);
        logic       vs, hr, fd;
        logic [7:0] d;
        int         b;
        vs = (p >= 1) && (p <= 20);
        fd = (p == 100);
        hr = 1'b0;
        d  = 8'h00;
        b  = -1;
        if (p >= 41 && p <= 56) b = p - 41;
        else if (p >= 61 && p <= 76) b = p - 61 + 16;
        if (b >= 0) begin
            hr = 1'b1;
            d  = pat ? bar_bytes[b % 16] : 8'(b);
        end
        return {vs, hr, fd, d};
    endfunction

    task automatic check_frame(input string tag, input int f, input logic pat);
        int bad = 0;
        for (int p = 1; p <= 100; p++) begin
            if ({cvs[f+p], chr[f+p], cfd[f+p], cd[f+p]} !== exp_at(p, pat)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int nz;
        int f_rst;

        reset   = 1'b1;
        en      = 1'b0;
        pattern = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_vsync", vsync, 0);
        check("reset_href", href, 0);
        check("reset_dout", dout, 0);
        check("reset_frame_done", frame_done, 0);

        reset = 1'b0;
        nz = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge pclk);
            #1;
            if ({vsync, href, frame_done, dout} !== 11'h0) nz++;
        end
        check("idle_200_cycles", nz, 0);

        // en is sampled on the edge captured as slot 1.
        en = 1'b1;
        pattern = 1'b0;
        while (gn < 547) begin
            step();
            if (gn == 210) pattern = 1'b1;
            if (gn == 366) begin
                en = 1'b0;
                pattern = 1'b0;
            end
            if (gn == 501) en = 1'b1;
        end

        check("vsync_before_rise", cvs[1], 0);
        check("vsync_rise", cvs[2], 1);
        check("vsync_last", cvs[21], 1);
        check("vsync_fall", cvs[22], 0);
        check("href_before_first", chr[41], 0);
        check("href_first", chr[42], 1);
        check("ramp_first", cd[42], 8'h00);
        check("ramp_line0_end", cd[57], 8'h0F);
        check("href_blank", chr[58], 0);
        check("ramp_line1_first", cd[62], 8'h10);
        check("ramp_last", cd[77], 8'h1F);
        check("frame_done_pulse", cfd[101], 1);
        check("vsync_back_to_back", cvs[102], 1);
        check("ramp_restart", cd[142], 8'h00);
        check_frame("frame1_ramp", 1, 1'b0);
        check_frame("frame2_ramp", 101, 1'b0);
        check_frame("frame3_pattern_latched", 201, 1'b0);

        check("bars_first", cd[342], 8'hFF);
        check("bars_byte3", cd[345], 8'hE0);
        check("bars_after_stop", cd[370], 8'hF8);
        check_frame("frame4_bars", 301, 1'b1);

        nz = 0;
        for (int i = 402; i <= 501; i++) begin
            if ({cvs[i], chr[i], cfd[i], cd[i]} !== 11'h0) nz++;
        end
        check("idle_after_stop", nz, 0);

        check("reenable_vsync_pre", cvs[502], 0);
        check("reenable_vsync", cvs[503], 1);
        check("reenable_href", chr[543], 1);
        check("reenable_ramp0", cd[543], 8'h00);
        check("reenable_ramp1", cd[544], 8'h01);
        check("reenable_ramp4", cd[547], 8'h04);

        // Asynchronous reset in the middle of line 0.
        reset = 1'b1;
        #2;
        check("midreset_outputs", {vsync, href, frame_done, dout}, 0);
        @(posedge pclk);
        #1;
        check("midreset_held", {vsync, href, frame_done, dout}, 0);
        reset = 1'b0;
        f_rst = gn + 1;
        for (int i = 0; i < 101; i++) step();
        check("post_reset_vsync_pre", cvs[f_rst], 0);
        check_frame("frame_after_reset", f_rst, 1'b0);

        en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
